uart_rx_os: RTL and testbench

Parametrised, oversampling UART receiver: the successor to the fixed-format 8-data/1-parity/1-stop receiver. It supports configurable data width, parity mode and stop-bit count, and resolves each bit by 3-sample majority vote at mid-bit. Completed words are delivered through a one-entry valid/ready output register with overrun and break detection. It sits between the pad-side serial input and the byte-consuming logic, alongside the existing baud controller.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_os_tick.sv | 33 +++
 rtl/uart_rx_os.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Expected parity bit for up to 9 data bits (unused upper bits must be 0).
  function automatic logic parity_exp(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversample tick generator: counts 0..div and strobes at div.
module uart_os_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick_c
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_c = en & ~clr & (cnt_q == div);

  // Next count: held at 0 while cleared, wraps after the strobe.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == div) ? '0 : cnt_q + DIV_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority vote and valid/ready output register.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned OS_RATE   = 16,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_en,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_ferror,
  output logic                 rx_perror,
  output logic                 rx_break,
  output logic                 rx_overrun
);

  localparam int unsigned BT_W = $clog2(OS_RATE);
  localparam int unsigned BC_W = 4;
  localparam logic [BT_W-1:0] S_FIRST = BT_W'(OS_RATE / 2 - 1);
  localparam logic [BT_W-1:0] S_LAST  = BT_W'(OS_RATE / 2 + 1);
  localparam logic [BT_W-1:0] BT_MAX  = BT_W'(OS_RATE - 1);

  logic                 sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  rx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [1:0]           pm_q, pm_d;
  logic                 two_q, two_d;
  logic [BT_W-1:0]      btick_q, btick_d;
  logic [2:0]           samp_q, samp_d;
  logic                 vpend_q, vpend_d;
  logic [BC_W-1:0]      bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 zero_q, zero_d, perr_q, perr_d, ferr_q, ferr_d, brk_q, brk_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d, rx_fe_q, rx_fe_d, rx_pe_q, rx_pe_d;
  logic                 rx_bk_q, rx_bk_d, rx_ovr_q, rx_ovr_d;

  logic fall_c, active_c, tick_c, vote_c, par_en_c, deliver_c, fe_c, bk_c, hs_c;

  assign fall_c   = prev_q & ~sync2_q;
  assign active_c = (state_q != IDLE) & rx_en;
  assign vote_c   = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);
  assign par_en_c = (pm_q == PAR_EVEN) || (pm_q == PAR_ODD);
  assign hs_c     = rx_valid_q & rx_ready;

  uart_os_tick #(.DIV_W(DIV_W)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clr    (~active_c),
    .en     (active_c),
    .div    (div_q),
    .tick_c (tick_c)
  );

  // Synchroniser, bit-tick counter and mid-bit sample capture.
  always_comb begin
    sync1_d = rxd;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    btick_d = btick_q;
    samp_d  = samp_q;
    vpend_d = 1'b0;
    if (!active_c) begin
      btick_d = '0;
    end else if (tick_c) begin
      btick_d = (btick_q == BT_MAX) ? '0 : btick_q + BT_W'(1);
      if (btick_q >= S_FIRST && btick_q <= S_LAST) samp_d = {samp_q[1:0], sync2_q};
      vpend_d = (btick_q == S_LAST);
    end
  end

  // Frame FSM: each state acts on the vote that follows the third sample.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    pm_d      = pm_q;
    two_d     = two_q;
    bcnt_d    = bcnt_q;
    data_d    = data_q;
    zero_d    = zero_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    brk_d     = brk_q;
    deliver_c = 1'b0;
    fe_c      = ferr_q | ~vote_c;
    bk_c      = (bcnt_q == '0) ? (zero_q & ~vote_c) : brk_q;
    unique case (state_q)
      IDLE: begin
        if (fall_c) begin
          state_d = START;
          div_d   = baud_div;
          pm_d    = parity_mode;
          two_d   = two_stop;
          bcnt_d  = '0;
          zero_d  = 1'b1;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
          brk_d   = 1'b0;
        end
      end
      START: begin
        if (vpend_q) state_d = vote_c ? IDLE : DATA;
      end
      DATA: begin
        if (vpend_q) begin
          data_d = {vote_c, data_q[DATA_BITS-1:1]};
          zero_d = zero_q & ~vote_c;
          if (bcnt_q == BC_W'(DATA_BITS - 1)) begin
            bcnt_d  = '0;
            state_d = par_en_c ? PARITY : STOP;
          end else begin
            bcnt_d = bcnt_q + BC_W'(1);
          end
        end
      end
      PARITY: begin
        if (vpend_q) begin
          perr_d  = vote_c != parity_exp(9'(data_q), pm_q == PAR_ODD);
          zero_d  = zero_q & ~vote_c;
          state_d = STOP;
        end
      end
      STOP: begin
        if (vpend_q) begin
          ferr_d = fe_c;
          brk_d  = bk_c;
          if (bcnt_q == '0 && two_q) begin
            bcnt_d = BC_W'(1);
          end else begin
            state_d   = IDLE;
            deliver_c = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!rx_en) begin
      state_d   = IDLE;
      deliver_c = 1'b0;
    end
  end

  // One-entry output register with overrun tracking.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_fe_d    = rx_fe_q;
    rx_pe_d    = rx_pe_q;
    rx_bk_d    = rx_bk_q;
    rx_ovr_d   = rx_ovr_q;
    if (deliver_c && (!rx_valid_q || hs_c)) begin
      rx_data_d  = data_q;
      rx_valid_d = 1'b1;
      rx_fe_d    = fe_c;
      rx_pe_d    = perr_q;
      rx_bk_d    = bk_c;
    end else if (hs_c) begin
      rx_valid_d = 1'b0;
    end
    if (hs_c)                         rx_ovr_d = 1'b0;
    else if (deliver_c && rx_valid_q) rx_ovr_d = 1'b1;
  end

  // All registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= IDLE;
      div_q      <= '0;
      pm_q       <= PAR_NONE;
      two_q      <= 1'b0;
      btick_q    <= '0;
      samp_q     <= '0;
      vpend_q    <= 1'b0;
      bcnt_q     <= '0;
      data_q     <= '0;
      zero_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_fe_q    <= 1'b0;
      rx_pe_q    <= 1'b0;
      rx_bk_q    <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      div_q      <= div_d;
      pm_q       <= pm_d;
      two_q      <= two_d;
      btick_q    <= btick_d;
      samp_q     <= samp_d;
      vpend_q    <= vpend_d;
      bcnt_q     <= bcnt_d;
      data_q     <= data_d;
      zero_q     <= zero_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_fe_q    <= rx_fe_d;
      rx_pe_q    <= rx_pe_d;
      rx_bk_q    <= rx_bk_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_ferror  = rx_fe_q;
  assign rx_perror  = rx_pe_q;
  assign rx_break   = rx_bk_q;
  assign rx_overrun = rx_ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: frame-level reference model plus directed literal checks.
module tb_uart_rx_os;

  localparam int unsigned DB = 8;
  localparam int unsigned OS = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_en = 1'b0;
  logic [DW-1:0] baud_div = 16'd3;
  logic [1:0]    parity_mode = 2'b00;
  logic          two_stop = 1'b0;
  logic          rxd = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid, rx_ferror, rx_perror, rx_break, rx_overrun;

  always #5 clk = ~clk;

  uart_rx_os #(.DATA_BITS(DB), .OS_RATE(OS), .DIV_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_en       (rx_en),
    .baud_div    (baud_div),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .rxd         (rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_ferror   (rx_ferror),
    .rx_perror   (rx_perror),
    .rx_break    (rx_break),
    .rx_overrun  (rx_overrun)
  );

  // A frame the model expects to land in the output stage at clock edge 'at'.
  typedef struct {
    int unsigned   at;
    logic [DB-1:0] data;
    logic          fe;
    logic          pe;
    logic          bk;
  } exp_t;

  exp_t          exp_q[$];
  int unsigned   cyc = 0;
  int            tests = 0;
  int            fails = 0;
  logic          m_valid = 1'b0, m_fe = 1'b0, m_pe = 1'b0, m_bk = 1'b0, m_ovr = 1'b0;
  logic [DB-1:0] m_data = '0;
  int unsigned   hs_cnt = 0, vcyc_cnt = 0;
  logic [DB-1:0] last_data = '0;
  logic          last_fe = 1'b0, last_pe = 1'b0, last_bk = 1'b0;
  bit            rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Compare DUT outputs with the model (called at the falling edge).
  task automatic compare();
    chk("valid", 32'(rx_valid), 32'(m_valid));
    chk("overrun", 32'(rx_overrun), 32'(m_ovr));
    if (m_valid) begin
      chk("data", 32'(rx_data), 32'(m_data));
      chk("ferror", 32'(rx_ferror), 32'(m_fe));
      chk("perror", 32'(rx_perror), 32'(m_pe));
      chk("break", 32'(rx_break), 32'(m_bk));
    end
    if (rx_valid) vcyc_cnt++;
    if (rx_valid && rx_ready) begin
      hs_cnt++;
      last_data = rx_data;
      last_fe   = rx_ferror;
      last_pe   = rx_perror;
      last_bk   = rx_break;
    end
  endtask

  // Model of the output stage at a rising edge, using the inputs seen at that edge.
  task automatic model_edge();
    logic hs;
    exp_t e;
    cyc++;
    if (reset) begin
      m_valid = 1'b0; m_data = '0; m_fe = 1'b0; m_pe = 1'b0; m_bk = 1'b0; m_ovr = 1'b0;
      exp_q.delete();
    end else begin
      hs = m_valid && rx_ready;
      if (exp_q.size() != 0 && exp_q[0].at == cyc) begin
        e = exp_q.pop_front();
        if (!m_valid || hs) begin
          m_valid = 1'b1; m_data = e.data; m_fe = e.fe; m_pe = e.pe; m_bk = e.bk;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (hs) begin
        m_valid = 1'b0;
      end
      if (hs) m_ovr = 1'b0;
    end
  endtask

  // One clock: check at the falling edge, model the rising edge, drive 1 time unit later.
  task automatic tick_cycle();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_edge();
    #1;
    if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
  endtask

  // Drive one frame; abort_kind 1 = reset, 2 = rx_en low, at mid-bit of abort_bit.
  task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] pm, input logic two,
                            input logic pbit, input logic s1, input logic s2,
                            input logic [DW-1:0] div, input int abort_bit,
                            input int abort_kind, input bit scramble);
    logic [15:0] fb;
    bit          pen;
    int          nb, idx;
    int unsigned n, bp, k;
    exp_t        e;
    parity_mode = pm;
    two_stop    = two;
    baud_div    = div;
    repeat (2) tick_cycle();
    pen = (pm == 2'b01) || (pm == 2'b10);
    fb  = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < int'(DB); i++) fb[1 + i] = d[i];
    idx = 1 + int'(DB);
    if (pen) begin
      fb[idx] = pbit;
      idx++;
    end
    fb[idx] = s1;
    if (two) fb[idx + 1] = s2;
    nb = idx + 1 + (two ? 1 : 0);
    bp = OS * (int'(div) + 1);
    tick_cycle();
    rxd = 1'b0;
    n   = cyc;
    if (abort_kind == 0) begin
      // Third sample of the last stop bit, plus sync and output latency.
      k      = unsigned'(nb - 1) * OS + OS / 2 + 1;
      e.at   = n + 5 + k * (int'(div) + 1) + int'(div);
      e.data = d;
      e.pe   = pen && (pbit != ((^d) ^ (pm == 2'b10)));
      e.fe   = !s1 || (two && !s2);
      e.bk   = (d == '0) && (!pen || !pbit) && !s1;
      exp_q.push_back(e);
    end
    for (int b = 0; b < nb; b++) begin
      if (b > 0) rxd = fb[b];
      if (b == 1 && scramble) begin
        baud_div    = 16'($urandom);
        parity_mode = 2'($urandom);
        two_stop    = 1'($urandom);
      end
      if (b == abort_bit) begin
        repeat (bp / 2) tick_cycle();
        rxd = 1'b1;
        if (abort_kind == 1) reset = 1'b1;
        else                 rx_en = 1'b0;
        tick_cycle();
        reset = 1'b0;
        repeat (3 * bp) tick_cycle();
        rx_en = 1'b1;
        return;
      end
      repeat (bp) tick_cycle();
    end
    rxd = 1'b1;
  endtask

  task automatic expect_held(input string name, input logic [DB-1:0] d, input logic fe,
                             input logic pe, input logic bk, input logic ovr);
    chk({name, ".valid"}, 32'(rx_valid), 32'd1);
    chk({name, ".data"}, 32'(rx_data), 32'(d));
    chk({name, ".ferror"}, 32'(rx_ferror), 32'(fe));
    chk({name, ".perror"}, 32'(rx_perror), 32'(pe));
    chk({name, ".break"}, 32'(rx_break), 32'(bk));
    chk({name, ".overrun"}, 32'(rx_overrun), 32'(ovr));
  endtask

  task automatic ack();
    rx_ready = 1'b1;
    tick_cycle();
    rx_ready = 1'b0;
    tick_cycle();
  endtask

  initial begin
    logic [DB-1:0] d;
    logic [1:0]    pm;
    logic          two, pb, s1, s2;
    logic [DW-1:0] dv;

    repeat (4) tick_cycle();
    reset = 1'b0;
    rx_en = 1'b1;
    tick_cycle();
    chk("reset.valid", 32'(rx_valid), 32'd0);
    chk("reset.data", 32'(rx_data), 32'd0);
    chk("reset.ferror", 32'(rx_ferror), 32'd0);
    chk("reset.perror", 32'(rx_perror), 32'd0);
    chk("reset.break", 32'(rx_break), 32'd0);
    chk("reset.overrun", 32'(rx_overrun), 32'd0);

    // 0x55, 8N1, ready held high: a single one-cycle valid pulse.
    rx_ready = 1'b1;
    hs_cnt = 0;
    vcyc_cnt = 0;
    send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3, -1, 0, 1'b0);
    repeat (4) tick_cycle();
    chk("p55.handshakes", 32'(hs_cnt), 32'd1);
    chk("p55.valid_cycles", 32'(vcyc_cnt), 32'd1);
    chk("p55.data", 32'(last_data), 32'h55);
    chk("p55.flags", {29'd0, last_fe, last_pe, last_bk}, 32'd0);
    rx_ready = 1'b0;

    // Parity, framing and break cases, read from the held register.
    send_frame(8'hA3, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 16'd3, -1, 0, 1'b0);
    expect_held("even_p1", 8'hA3, 1'b0, 1'b1, 1'b0, 1'b0);
    ack();
    send_frame(8'hA3, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3, -1, 0, 1'b0);
    expect_held("even_p0", 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
    ack();
    send_frame(8'hA3, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3, -1, 0, 1'b0);
    expect_held("odd_p0", 8'hA3, 1'b0, 1'b1, 1'b0, 1'b0);
    ack();
    send_frame(8'h3C, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 16'd3, -1, 0, 1'b0);
    expect_held("stop2_low", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    ack();
    send_frame(8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3, -1, 0, 1'b0);
    expect_held("break", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    ack();

    // False start: 4-tick low pulse, then a clean frame.
    tick_cycle();
    rxd = 1'b0;
    repeat (4 * 4) tick_cycle();
    rxd = 1'b1;
    repeat (2 * OS * 4) tick_cycle();
    chk("glitch.valid", 32'(rx_valid), 32'd0);
    send_frame(8'h81, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3, -1, 0, 1'b0);
    expect_held("after_glitch", 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    ack();

    // Overrun while the held word is not taken.
    send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3, -1, 0, 1'b0);
    send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3, -1, 0, 1'b0);
    expect_held("overrun", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    ack();
    chk("ovr_ack.valid", 32'(rx_valid), 32'd0);
    chk("ovr_ack.overrun", 32'(rx_overrun), 32'd0);
    send_frame(8'h33, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3, -1, 0, 1'b0);
    expect_held("after_ovr", 8'h33, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during D4 clears the held word; rx_en drop discards the partial frame.
    send_frame(8'h77, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3, 5, 1, 1'b0);
    chk("rst_mid.valid", 32'(rx_valid), 32'd0);
    chk("rst_mid.data", 32'(rx_data), 32'd0);
    send_frame(8'h66, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3, 3, 2, 1'b0);
    chk("en_drop.valid", 32'(rx_valid), 32'd0);
    send_frame(8'hF0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3, -1, 0, 1'b0);
    expect_held("after_abort", 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    ack();

    // Randomised frames, random consumer back-pressure, config scrambled mid-frame.
    rand_rdy = 1'b1;
    for (int f = 0; f < 30; f++) begin
      d   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      pm  = 2'($urandom);
      two = 1'($urandom);
      dv  = 16'($urandom_range(0, 2));
      pb  = (^d) ^ (pm == 2'b10);
      if ($urandom_range(0, 3) == 0) pb = ~pb;
      if (d == 8'h00 && $urandom_range(0, 1) == 0) pb = 1'b0;
      s1  = ($urandom_range(0, 5) != 0);
      s2  = ($urandom_range(0, 5) != 0);
      send_frame(d, pm, two, pb, s1, s2, dv, -1, 0, 1'($urandom));
      repeat ($urandom_range(0, 20)) tick_cycle();
    end
    rand_rdy = 1'b0;
    rx_ready = 1'b1;
    repeat (8) tick_cycle();
    chk("drain.valid", 32'(rx_valid), 32'd0);
    chk("drain.overrun", 32'(rx_overrun), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
